// File: rtl/merge_pkg.sv
// Shared types and constant helpers for the lane merger / packing buffer.
package merge_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_LAST  = 2'd2
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r++;
    return r;
  endfunction

  // MSB index of slice idx in a bus of num slices, slice 0 most significant
  function automatic int lane_hi(input int idx, input int num, input int width);
    return (num - idx) * width - 1;
  endfunction

endpackage

// File: rtl/byte_compactor.sv
// Combinational: clamps lane lengths and packs valid lane bytes MSB-first, lane 0 leading.
// Bytes past count_o are zero, so the result can be OR-merged into a zero tail.
module byte_compactor
  import merge_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int LANE_BYTES = 4,
  parameter int LW         = clog2(LANE_BYTES + 1),
  parameter int CW         = clog2(NUM_CH * LANE_BYTES + 1)
) (
  input  logic [NUM_CH*LANE_BYTES*8-1:0] data_i,
  input  logic [NUM_CH*LW-1:0]           len_i,
  output logic [NUM_CH*LANE_BYTES*8-1:0] data_o,
  output logic [CW-1:0]                  count_o
);

  localparam int LB8 = LANE_BYTES * 8;
  localparam int VW  = NUM_CH * LB8;

  logic [LW-1:0]  len_c;
  logic [LB8-1:0] lane_m;
  logic [VW-1:0]  wide;
  logic [CW-1:0]  off;

  always_comb begin
    data_o = '0;
    off    = '0;
    len_c  = '0;
    lane_m = '0;
    wide   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      len_c = len_i[lane_hi(i, NUM_CH, LW) -: LW];
      if (len_c > LW'(LANE_BYTES)) len_c = LW'(LANE_BYTES);
      // keep the top len_c bytes of the lane, zero the rest
      lane_m = data_i[lane_hi(i, NUM_CH, LB8) -: LB8] & ~({LB8{1'b1}} >> (32'(len_c) * 8));
      wide   = VW'(lane_m) << (VW - LB8);
      data_o = data_o | (wide >> (32'(off) * 8));
      off    = off + CW'(len_c);
    end
    count_o = off;
  end

endmodule

// File: rtl/merge_packer.sv
// Merges NUM_CH variable-length lanes into fixed OUT_BYTES words; bytes visible one cycle after accept.
// in_ready depends only on registered state; outputs hold steady while stalled; flush emits a last word.
module merge_packer
  import merge_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int LANE_BYTES = 4,
  parameter int OUT_BYTES  = 8,
  parameter int LW         = clog2(LANE_BYTES + 1),
  parameter int OW         = clog2(OUT_BYTES + 1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_CH*LANE_BYTES*8-1:0] data_in,
  input  logic [NUM_CH*LW-1:0]           len_in,
  input  logic                           flush_in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [OUT_BYTES*8-1:0]         data_out,
  output logic [OW-1:0]                  out_len,
  output logic                           out_last
);

  localparam int IN_BYTES  = NUM_CH * LANE_BYTES;
  localparam int ACC_BYTES = OUT_BYTES + IN_BYTES;
  localparam int FW        = clog2(ACC_BYTES + 1);
  localparam int CW        = clog2(IN_BYTES + 1);

  state_e                 state_q, state_d;
  logic [FW-1:0]          fill_q, fill_d, fill_pop;
  logic [ACC_BYTES*8-1:0] acc_q, acc_d, acc_pop;
  logic [IN_BYTES*8-1:0]  comp_dat;
  logic [CW-1:0]          comp_cnt;
  logic                   last_st, push, pop;

  byte_compactor #(
    .NUM_CH     (NUM_CH),
    .LANE_BYTES (LANE_BYTES),
    .LW         (LW),
    .CW         (CW)
  ) u_compactor (
    .data_i  (data_in),
    .len_i   (len_in),
    .data_o  (comp_dat),
    .count_o (comp_cnt)
  );

  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    acc_d     = acc_q;
    fill_pop  = fill_q;
    acc_pop   = acc_q;
    last_st   = (state_q == ST_LAST);
    in_ready  = (state_q == ST_RUN) && (fill_q <= FW'(ACC_BYTES - IN_BYTES));
    out_valid = last_st || (fill_q >= FW'(OUT_BYTES));
    out_last  = last_st;
    data_out  = acc_q[ACC_BYTES*8-1 -: OUT_BYTES*8];
    out_len   = '0;
    if (last_st)        out_len = OW'(fill_q);
    else if (out_valid) out_len = OW'(OUT_BYTES);
    push = in_valid && in_ready;
    pop  = out_valid && out_ready;

    // pop first so an appended beat lands behind the remaining bytes
    if (pop) begin
      if (last_st) begin
        fill_pop = '0;
        acc_pop  = '0;
        state_d  = ST_RUN;
      end else begin
        fill_pop = fill_q - FW'(OUT_BYTES);
        acc_pop  = acc_q << (OUT_BYTES * 8);
      end
    end

    acc_d  = acc_pop;
    fill_d = fill_pop;
    if (push) begin
      acc_d  = acc_pop | ({comp_dat, {(OUT_BYTES*8){1'b0}}} >> (32'(fill_pop) * 8));
      fill_d = fill_pop + FW'(comp_cnt);
      if (flush_in) state_d = ST_FLUSH;
    end

    if (state_q == ST_FLUSH && fill_q < FW'(OUT_BYTES)) state_d = ST_LAST;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      fill_q  <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      acc_q   <= acc_d;
    end
  end

endmodule
